// File: rtl/one_to_two_demux_if.sv
// Bus bundle for the 1-to-2 demux: one data/select source, two routed outputs.
interface one_to_two_demux_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] I;
    logic             select;
    logic [WIDTH-1:0] Y0;
    logic [WIDTH-1:0] Y1;

    modport master (
        output I,
        output select,
        input  Y0,
        input  Y1
    );

    modport slave (
        input  I,
        input  select,
        output Y0,
        output Y1
    );
endinterface

// File: rtl/one_to_two_demux.sv
// 1-to-2 demultiplexer: steers I to Y0 or Y1 by select, zeroing the other port.
// Outputs are optionally registered with an asynchronous active-low reset.
module one_to_two_demux #(
    parameter int WIDTH        = 1,
    parameter bit REGISTER_OUT = 1'b1
) (
    input logic               clk,
    input logic               rst_n,
    one_to_two_demux_if.slave bus
);

    logic [WIDTH-1:0] y0_n;
    logic [WIDTH-1:0] y1_n;

    // A ternary on select lets an X select propagate X rather than pick a route.
    always_comb begin
        y0_n = bus.select ? '0 : bus.I;
        y1_n = bus.select ? bus.I : '0;
    end

    generate
        if (REGISTER_OUT) begin : g_reg
            logic [WIDTH-1:0] y0_q;
            logic [WIDTH-1:0] y1_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    y0_q <= '0;
                    y1_q <= '0;
                end else begin
                    y0_q <= y0_n;
                    y1_q <= y1_n;
                end
            end

            assign bus.Y0 = y0_q;
            assign bus.Y1 = y1_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;

            assign bus.Y0 = y0_n;
            assign bus.Y1 = y1_n;
        end
    endgenerate

endmodule

// File: tb/tb_one_to_two_demux.sv
// Self-checking bench: a registered WIDTH=1 demux and a combinational WIDTH=8 demux
// checked against a history-based routing model plus literal directed expectations.
module tb_one_to_two_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    one_to_two_demux_if #(.WIDTH(1)) reg_if ();
    one_to_two_demux_if #(.WIDTH(8)) comb_if ();

    one_to_two_demux #(.WIDTH(1), .REGISTER_OUT(1'b1)) dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (reg_if)
    );

    one_to_two_demux #(.WIDTH(8), .REGISTER_OUT(1'b0)) dut_comb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (comb_if)
    );

    always #5 clk = ~clk;

    // Routing rule as arithmetic: the selected port gets I, the other gets zero.
    function automatic logic [15:0] route(input logic [7:0] i, input logic sel);
        int s;
        int y0;
        int y1;
        s  = int'(sel);
        y0 = int'(i) * (1 - s);
        y1 = int'(i) * s;
        return {y1[7:0], y0[7:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic i, input logic sel);
        @(posedge clk);
        #2;
        reg_if.I      = i;
        reg_if.select = sel;
    endtask

    // Model of the registered DUT: the pair sampled at the last clean edge since reset.
    logic [8:0] hist[$];

    always @(negedge rst_n) hist.delete();

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            hist.push_back({reg_if.select, 7'd0, reg_if.I});
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [15:0] exp_reg;
        logic [15:0] exp_comb;
        exp_reg  = (hist.size() == 0) ? 16'd0 : route(hist[$][7:0], hist[$][8]);
        exp_comb = route(comb_if.I, comb_if.select);
        checkOutput("model_reg_y0", {7'd0, reg_if.Y0}, exp_reg[7:0]);
        checkOutput("model_reg_y1", {7'd0, reg_if.Y1}, exp_reg[15:8]);
        checkOutput("model_reg_excl", {7'd0, reg_if.Y0 & reg_if.Y1}, 8'd0);
        checkOutput("model_comb_y0", comb_if.Y0, exp_comb[7:0]);
        checkOutput("model_comb_y1", comb_if.Y1, exp_comb[15:8]);
        checkOutput("model_comb_excl", comb_if.Y0 & comb_if.Y1, 8'd0);
    end

    logic table_i   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic table_sel [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic table_y0  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic table_y1  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        reg_if.I       = 1'b1;
        reg_if.select  = 1'b1;
        comb_if.I      = 8'h00;
        comb_if.select = 1'b0;

        // Reset asserts without any clock edge; the comb instance ignores it.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_async_y0", {7'd0, reg_if.Y0}, 8'd0);
        checkOutput("rst_async_y1", {7'd0, reg_if.Y1}, 8'd0);
        comb_if.I      = 8'hA5;
        comb_if.select = 1'b1;
        #1;
        checkOutput("comb_sel1_y1", comb_if.Y1, 8'hA5);
        checkOutput("comb_sel1_y0", comb_if.Y0, 8'h00);
        comb_if.select = 1'b0;
        #1;
        checkOutput("comb_sel0_y0", comb_if.Y0, 8'hA5);
        checkOutput("comb_sel0_y1", comb_if.Y1, 8'h00);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_hold_y1", {7'd0, reg_if.Y1}, 8'd0);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("rst_release_pre_y1", {7'd0, reg_if.Y1}, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_release_y1", {7'd0, reg_if.Y1}, 8'd1);
        checkOutput("rst_release_y0", {7'd0, reg_if.Y0}, 8'd0);

        for (int k = 0; k < 5; k++) begin
            applyStimulus(table_i[k], table_sel[k]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("table%0d_y0", k), {7'd0, reg_if.Y0}, {7'd0, table_y0[k]});
            checkOutput($sformatf("table%0d_y1", k), {7'd0, reg_if.Y1}, {7'd0, table_y1[k]});
        end

        applyStimulus(1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("lat_setup_y0", {7'd0, reg_if.Y0}, 8'd1);
        applyStimulus(1'b1, 1'b1);
        @(negedge clk);
        checkOutput("lat_before_y0", {7'd0, reg_if.Y0}, 8'd1);
        checkOutput("lat_before_y1", {7'd0, reg_if.Y1}, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_after_y0", {7'd0, reg_if.Y0}, 8'd0);
        checkOutput("lat_after_y1", {7'd0, reg_if.Y1}, 8'd1);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_async_y1", {7'd0, reg_if.Y1}, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_hold_y1", {7'd0, reg_if.Y1}, 8'd0);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("mid_rst_released_y1", {7'd0, reg_if.Y1}, 8'd0);
        @(posedge clk);
        #1;
        checkOutput("mid_rst_recapture_y1", {7'd0, reg_if.Y1}, 8'd1);

        // Random traffic with occasional short reset pulses between edges.
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #2;
            reg_if.I       = 1'($urandom_range(1));
            reg_if.select  = 1'($urandom_range(1));
            comb_if.I      = 8'($urandom_range(255));
            comb_if.select = 1'($urandom_range(1));
            if ($urandom_range(49) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
